// File: rtl/multiplier_control.sv
// Control FSM for the 8-bit shift-add two's-complement multiplier datapath.
// Synchronizes the Run / Load_Clear buttons and issues one-cycle datapath commands.
module multiplier_control #(
   parameter int N_BITS      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     Run_i,
   input  logic                     Load_Clear_i,
   input  logic                     M,
   output logic                     Clr_XA,
   output logic                     Ld_B,
   output logic                     Add,
   output logic                     Sub,
   output logic                     Shift,
   output logic                     Busy,
   output logic                     Done,
   output logic [2:0]               State,
   output logic [$clog2(N_BITS):0]  Count
);

   localparam int CW = $clog2(N_BITS) + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_ADD   = 3'd2,
      S_SHIFT = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           count_q, count_d;
   logic [SYNC_STAGES-1:0]  run_sync_q, run_sync_d;
   logic [SYNC_STAGES-1:0]  lc_sync_q, lc_sync_d;
   logic                    run_prev_q, lc_prev_q;
   logic                    run_edge, lc_edge;
   logic                    last_iter;

   assign run_sync_d = {run_sync_q[SYNC_STAGES-2:0], Run_i};
   assign lc_sync_d  = {lc_sync_q[SYNC_STAGES-2:0], Load_Clear_i};

   // Sync and history flops reset high so a button held through reset gives no edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         run_sync_q <= '1;
         lc_sync_q  <= '1;
         run_prev_q <= 1'b1;
         lc_prev_q  <= 1'b1;
      end else begin
         run_sync_q <= run_sync_d;
         lc_sync_q  <= lc_sync_d;
         run_prev_q <= run_sync_q[SYNC_STAGES-1];
         lc_prev_q  <= lc_sync_q[SYNC_STAGES-1];
      end
   end

   assign run_edge  = run_sync_q[SYNC_STAGES-1] & ~run_prev_q;
   assign lc_edge   = lc_sync_q[SYNC_STAGES-1] & ~lc_prev_q;
   assign last_iter = (count_q == CW'(N_BITS - 1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            // Load_Clear wins a same-cycle tie; the Run edge is simply dropped.
            if (lc_edge) begin
               state_d = S_IDLE;
            end else if (run_edge) begin
               state_d = S_CLR;
               count_d = '0;
            end
         end
         S_CLR:   state_d = S_ADD;
         S_ADD:   state_d = S_SHIFT;
         S_SHIFT: begin
            count_d = count_q + CW'(1);
            state_d = last_iter ? S_HOLD : S_ADD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Clr_XA = 1'b0;
      Ld_B   = 1'b0;
      Add    = 1'b0;
      Sub    = 1'b0;
      Shift  = 1'b0;
      Busy   = 1'b0;
      Done   = 1'b0;
      case (state_q)
         S_IDLE: begin
            Ld_B   = lc_edge;
            Clr_XA = lc_edge;
         end
         S_CLR: begin
            Clr_XA = 1'b1;
            Busy   = 1'b1;
         end
         S_ADD: begin
            Busy = 1'b1;
            // The final partial product carries the sign weight, so it is subtracted.
            Add  = M & ~last_iter;
            Sub  = M & last_iter;
         end
         S_SHIFT: begin
            Shift = 1'b1;
            Busy  = 1'b1;
         end
         S_HOLD: begin
            Done   = ~lc_edge;
            Ld_B   = lc_edge;
            Clr_XA = lc_edge;
         end
         default: ;
      endcase
   end

   assign State = state_q;
   assign Count = count_q;

endmodule

// File: tb/tb_multiplier_control.sv
// Directed self-checking bench for multiplier_control with a small B-register stub
// that feeds M the way the datapath does.
module tb_multiplier_control;

   logic       Clk, Reset_n, Run_i, Load_Clear_i, M;
   logic       Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done;
   logic [2:0] State;
   logic [3:0] Count;

   int tot = 0;
   int bad = 0;

   multiplier_control #(.N_BITS(8), .SYNC_STAGES(2)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run_i(Run_i), .Load_Clear_i(Load_Clear_i),
      .M(M), .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Add(Add), .Sub(Sub), .Shift(Shift),
      .Busy(Busy), .Done(Done), .State(State), .Count(Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [7:0] b_q = 8'h00;
   logic [7:0] sw  = 8'h00;
   always @(posedge Clk) begin
      if (Ld_B)       b_q <= sw;
      else if (Shift) b_q <= {1'b0, b_q[7:1]};
   end
   assign M = b_q[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tot++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int m_busy, m_shift, m_both, m_ld, m_clr, m_done;
   logic [7:0] m_addm, m_subm;

   task automatic press_run(output int lat);
      Run_i = 1'b1;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(negedge Clk);
         if (State == 3'd1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic monitor(input bit inj);
      m_busy = 0; m_shift = 0; m_both = 0; m_ld = 0; m_clr = 0; m_done = 0;
      m_addm = '0; m_subm = '0;
      for (int i = 0; i < 60; i++) begin
         if (Done) begin
            m_done = 1;
            break;
         end
         m_busy  += int'(Busy);
         m_shift += int'(Shift);
         m_ld    += int'(Ld_B);
         m_clr   += int'(Clr_XA);
         if (Add) m_addm[Count[2:0]] = 1'b1;
         if (Sub) m_subm[Count[2:0]] = 1'b1;
         if (Add && Sub) m_both = 1;
         if (inj) begin
            case (i)
               2: Load_Clear_i = 1'b1;
               5: begin Load_Clear_i = 1'b0; Run_i = 1'b0; end
               8: Run_i = 1'b1;
               default: ;
            endcase
         end
         @(negedge Clk);
      end
   endtask

   task automatic lc_pulse(input logic [7:0] v, output int ld, output int clr, output int nid);
      sw = v;
      Load_Clear_i = 1'b1;
      ld = 0; clr = 0; nid = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         ld  += int'(Ld_B);
         clr += int'(Clr_XA);
         if (State != 3'd0) nid++;
      end
      Load_Clear_i = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic hold_check(input string tag);
      int n;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (State != 3'd4) n++;
      end
      chk(tag, n, 0);
   endtask

   task automatic run_checks(input string tag, input logic [7:0] addm, input logic [7:0] subm);
      chk({tag, "_done"},  m_done, 1);
      chk({tag, "_busy"},  m_busy, 17);
      chk({tag, "_shift"}, m_shift, 8);
      chk({tag, "_addm"},  m_addm, addm);
      chk({tag, "_subm"},  m_subm, subm);
      chk({tag, "_both"},  m_both, 0);
      chk({tag, "_ldb"},   m_ld, 0);
      chk({tag, "_clr"},   m_clr, 1);
      chk({tag, "_count"}, Count, 8);
      chk({tag, "_state"}, State, 4);
   endtask

   initial begin
      int lat, ld, clr, nid, n, found;
      Reset_n = 1'b0; Run_i = 1'b1; Load_Clear_i = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      chk("rst_state", State, 0);
      chk("rst_count", Count, 0);
      chk("rst_cmds", {Clr_XA, Ld_B, Add, Sub, Shift}, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (State != 3'd0) n++;
      end
      chk("held_run_no_clr", n, 0);

      Run_i = 1'b0;
      repeat (4) @(negedge Clk);
      press_run(lat);
      chk("lat1", lat, 3);
      monitor(1'b0);
      run_checks("run0", 8'h00, 8'h00);
      hold_check("hold_held0");
      Run_i = 1'b0;
      repeat (4) @(negedge Clk);

      lc_pulse(8'h07, ld, clr, nid);
      chk("lc_hold_ld", ld, 1);
      chk("lc_hold_clr", clr, 1);
      chk("lc_hold_state", State, 0);
      chk("lc_hold_done", Done, 0);
      lc_pulse(8'h07, ld, clr, nid);
      chk("lc_idle_ld", ld, 1);
      chk("lc_idle_clr", clr, 1);
      chk("lc_idle_nid", nid, 0);

      press_run(lat);
      chk("lat07", lat, 3);
      monitor(1'b0);
      run_checks("b07", 8'h07, 8'h00);
      Run_i = 1'b0;
      repeat (4) @(negedge Clk);

      lc_pulse(8'h80, ld, clr, nid);
      press_run(lat);
      chk("lat80", lat, 3);
      monitor(1'b1);
      run_checks("b80", 8'h00, 8'h80);
      hold_check("hold_held80");
      Run_i = 1'b0;
      repeat (4) @(negedge Clk);
      press_run(lat);
      chk("lat_again", lat, 3);
      monitor(1'b0);
      run_checks("again", 8'h00, 8'h00);
      Run_i = 1'b0;
      repeat (4) @(negedge Clk);

      lc_pulse(8'hFF, ld, clr, nid);
      press_run(lat);
      found = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clk);
         if (State == 3'd2 && Count == 4'd4) begin
            found = 1;
            break;
         end
      end
      chk("mid_found", found, 1);
      chk("mid_add", Add, 1);
      Reset_n = 1'b0;
      Run_i = 1'b0;
      #1;
      chk("mid_rst_state", State, 0);
      chk("mid_rst_count", Count, 0);
      chk("mid_rst_busy", Busy, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);

      sw = 8'h3C;
      Run_i = 1'b1;
      Load_Clear_i = 1'b1;
      ld = 0; clr = 0; nid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         ld  += int'(Ld_B);
         clr += int'(Clr_XA);
         if (State != 3'd0) nid++;
      end
      chk("tie_ld", ld, 1);
      chk("tie_clr", clr, 1);
      chk("tie_nid", nid, 0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
